// File: rtl/led_matrix_pwm_scan.sv
// Group-multiplexed LED matrix driver: per-cell PWM levels scaled by a global dimmer,
// blanking gap before each group's drive slot, and a one-group-per-clock clear sweep.
module led_matrix_pwm_scan #(
  parameter int LEDS_N          = 10,
  parameter int LEDS_M          = 8,
  parameter int N_BITS          = 4,
  parameter int M_BITS          = 4,
  parameter int PWM_BITS        = 8,
  parameter int LED_PERIOD_BITS = 24,
  parameter int BLANK_CYCLES    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [LED_PERIOD_BITS-1:0] led_period,
  input  logic [PWM_BITS-1:0]        global_brightness,
  input  logic                       wr,
  input  logic [N_BITS-1:0]          wr_n,
  input  logic [M_BITS-1:0]          wr_m,
  input  logic [PWM_BITS-1:0]        wr_level,
  output logic                       wr_ready,
  input  logic                       clear,
  output logic [LEDS_N-1:0]          n_en,
  output logic [LEDS_M-1:0]          m_en,
  output logic                       done_tick,
  output logic                       busy
);
  localparam int PW = 2*PWM_BITS+1;

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;
  state_t state, state_d;

  logic [N_BITS-1:0]          grp, grp_d, sweep_idx;
  logic [LED_PERIOD_BITS-1:0] cnt, cnt_d, period, period_d;
  logic [PWM_BITS-1:0]        pwm_cnt, pwm_d;
  logic                       load_shadow, done_d, sweep_on, we;

  logic [LEDS_N-1:0][LEDS_M-1:0][PWM_BITS-1:0] cells;
  logic [LEDS_M-1:0][PWM_BITS-1:0]             shadow, cur_row, lv_src;
  logic [LEDS_N-1:0] n_en_d;
  logic [LEDS_M-1:0] m_on, m_en_d;

  assign we = wr && wr_ready && !clear;

  always_comb begin
    cur_row = '0;
    for (int n = 0; n < LEDS_N; n++)
      if (grp == N_BITS'(n)) cur_row = cells[n];
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    grp_d       = grp;
    period_d    = period;
    pwm_d       = pwm_cnt;
    load_shadow = 1'b0;
    done_d      = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      grp_d   = '0;
      pwm_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
        end
        BLANK: begin
          if (cnt == LED_PERIOD_BITS'(BLANK_CYCLES-1)) begin
            state_d     = DRIVE;
            cnt_d       = '0;
            pwm_d       = '0;
            load_shadow = 1'b1;
            period_d    = (led_period == '0) ? LED_PERIOD_BITS'(1) : led_period;
          end else begin
            cnt_d = cnt + LED_PERIOD_BITS'(1);
          end
        end
        DRIVE: begin
          pwm_d = pwm_cnt + PWM_BITS'(1);
          if (cnt == period - LED_PERIOD_BITS'(1)) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (grp == N_BITS'(LEDS_N-1)) begin
              grp_d  = '0;
              done_d = 1'b1;
            end else begin
              grp_d = grp + N_BITS'(1);
            end
          end else begin
            cnt_d = cnt + LED_PERIOD_BITS'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are registered from next-state values so n_en and m_en line up with the slot.
  assign lv_src = load_shadow ? cur_row : shadow;

  for (genvar m = 0; m < LEDS_M; m++) begin : g_row
    logic [PW-1:0] eff;
    assign eff     = (PW'(lv_src[m]) * (PW'(global_brightness) + PW'(1))) >> PWM_BITS;
    assign m_on[m] = PW'(pwm_d) < eff;
  end

  always_comb begin
    n_en_d = '0;
    for (int n = 0; n < LEDS_N; n++)
      n_en_d[n] = (state_d == DRIVE) && (grp_d == N_BITS'(n));
    m_en_d = (state_d == DRIVE) ? m_on : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      grp       <= '0;
      period    <= LED_PERIOD_BITS'(1);
      pwm_cnt   <= '0;
      shadow    <= '0;
      n_en      <= '0;
      m_en      <= '0;
      done_tick <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      grp       <= grp_d;
      period    <= period_d;
      pwm_cnt   <= pwm_d;
      if (load_shadow) shadow <= cur_row;
      n_en      <= n_en_d;
      m_en      <= m_en_d;
      done_tick <= done_d;
      busy      <= (state_d != IDLE);
    end
  end

  // A new clear restarts the sweep; the edge that samples clear zeroes nothing yet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cells     <= '0;
      sweep_on  <= 1'b0;
      sweep_idx <= '0;
      wr_ready  <= 1'b1;
    end else begin
      if (clear) begin
        sweep_on  <= 1'b1;
        sweep_idx <= '0;
        wr_ready  <= 1'b0;
      end else if (sweep_on) begin
        if (sweep_idx == N_BITS'(LEDS_N-1)) begin
          sweep_on <= 1'b0;
          wr_ready <= 1'b1;
        end else begin
          sweep_idx <= sweep_idx + N_BITS'(1);
        end
      end
      for (int n = 0; n < LEDS_N; n++)
        for (int m = 0; m < LEDS_M; m++)
          if (sweep_on && !clear && sweep_idx == N_BITS'(n))
            cells[n][m] <= '0;
          else if (we && wr_n == N_BITS'(n) && wr_m == M_BITS'(m))
            cells[n][m] <= wr_level;
    end
  end
endmodule

// File: tb/tb_led_matrix_pwm_scan.sv
// Bench for led_matrix_pwm_scan: per-cycle reference model built from frame/slot time
// arithmetic, a brightness vector table, directed corner sequences and a random phase.
module tb_led_matrix_pwm_scan;
  localparam int N = 10, M = 8, B = 16;

  logic        clk, reset, en, wr, clear;
  logic [23:0] led_period;
  logic [7:0]  global_brightness, wr_level;
  logic [3:0]  wr_n, wr_m;
  logic        wr_ready, done_tick, busy;
  logic [N-1:0] n_en;
  logic [M-1:0] m_en;

  led_matrix_pwm_scan dut (
    .clk(clk), .reset(reset), .en(en), .led_period(led_period),
    .global_brightness(global_brightness), .wr(wr), .wr_n(wr_n), .wr_m(wr_m),
    .wr_level(wr_level), .wr_ready(wr_ready), .clear(clear), .n_en(n_en),
    .m_en(m_en), .done_tick(done_tick), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  // reference model state
  int   mcells[N][M];
  int   mshadow[M];
  bit   running, mready;
  int   t, P, sweep_pos;
  logic [N-1:0] e_n;
  logic [M-1:0] e_m;
  bit   e_done, e_busy;

  typedef struct { int level; int gb; int period; int exp_on; } bvec_t;
  bvec_t tbl[8];

  task automatic model_reset();
    for (int n = 0; n < N; n++) for (int m = 0; m < M; m++) mcells[n][m] = 0;
    for (int m = 0; m < M; m++) mshadow[m] = 0;
    running = 0; mready = 1; t = 0; P = 1; sweep_pos = -1;
    e_n = '0; e_m = '0; e_done = 0; e_busy = 0;
  endtask

  // Expected outputs after the coming edge, from the inputs presented now.
  task automatic model_update();
    int S, p, g, o, k;
    bit wr_ok;
    e_n = '0; e_m = '0; e_done = 0; e_busy = 0;
    if (!en) begin
      running = 0;
    end else begin
      if (!running) begin
        running = 1; t = 0; P = (led_period == 0) ? 1 : int'(led_period);
      end else t++;
      S = B + P; p = t % (N*S); g = p / S; o = p % S;
      e_busy = 1;
      e_done = (t != 0) && (p == 0);
      if (o >= B) begin
        k = o - B;
        if (k == 0) for (int m = 0; m < M; m++) mshadow[m] = mcells[g][m];
        e_n[g] = 1'b1;
        for (int m = 0; m < M; m++)
          e_m[m] = (k % 256) < (mshadow[m] * (int'(global_brightness) + 1)) / 256;
      end
    end
    wr_ok = wr && mready && !clear;
    if (clear) sweep_pos = 0;
    else if (sweep_pos >= 0) begin
      for (int m = 0; m < M; m++) mcells[sweep_pos][m] = 0;
      sweep_pos++;
      if (sweep_pos == N) sweep_pos = -1;
    end
    if (wr_ok && wr_n < N && wr_m < M) mcells[wr_n][wr_m] = int'(wr_level);
    mready = (sweep_pos < 0);
  endtask

  task automatic check_out(input string name);
    vectors++;
    if (n_en !== e_n || m_en !== e_m || done_tick !== e_done || busy !== e_busy || wr_ready !== mready) begin
      miscompares++;
      $display("FAIL %s t=%0t: got n_en=%h m_en=%h done=%b busy=%b rdy=%b, want %h %h %b %b %b",
               name, $time, n_en, m_en, done_tick, busy, wr_ready, e_n, e_m, e_done, e_busy, mready);
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk); #1;
    check_out("scan");
  endtask

  task automatic write_cell(input int n, input int m, input int lv);
    wr = 1; wr_n = 4'(n); wr_m = 4'(m); wr_level = 8'(lv);
    step();
    wr = 0;
  endtask

  task automatic do_reset();
    reset = 1; en = 0; wr = 0; clear = 0;
    #1;
    check_val("reset_out", int'({n_en, m_en, done_tick, busy}), 0);
    check_val("reset_rdy", int'(wr_ready), 1);
    model_reset();
    @(posedge clk); #1;
    reset = 0;
  endtask

  // Wait for group g's slot, count cycles with m_en[row] set; optional write mid-slot.
  task automatic slot_duty(input int g, input int row, input int wr_at, input int wr_lv, output int on);
    int i, j;
    i = 0; on = 0; j = 0;
    while (!n_en[g] && i < 5000) begin step(); i++; end
    if (!n_en[g]) check_val("slot_timeout", 0, 1);
    while (n_en[g] && j < 5000) begin
      if (m_en[row]) on++;
      if (j == wr_at) begin wr = 1; wr_n = 4'(g); wr_m = 4'(row); wr_level = 8'(wr_lv); end
      step();
      wr = 0;
      j++;
    end
  endtask

  task automatic scan_any_lit(input int steps, output int lit);
    lit = 0;
    repeat (steps) begin step(); if (m_en != 0) lit++; end
  endtask

  initial begin
    int on, c, lit;
    tbl[0] = '{128, 255, 256, 128};
    tbl[1] = '{128, 127, 256, 64};
    tbl[2] = '{128,   0, 256, 0};
    tbl[3] = '{255, 255, 256, 255};
    tbl[4] = '{  0, 255, 256, 0};
    tbl[5] = '{ 16,  15, 256, 1};
    tbl[6] = '{200, 255,  20, 20};
    tbl[7] = '{  1, 255,   5, 1};

    led_period = 24'd5; global_brightness = 8'd255;
    wr_n = 0; wr_m = 0; wr_level = 0;
    do_reset();

    // basic frame timing: 10*(16+5) clocks per frame, one done pulse per frame
    en = 1; c = 0;
    repeat (2*N*(B+5) + 1) begin step(); if (done_tick) c++; end
    check_val("done_pulses", c, 2);

    // brightness table
    for (int i = 0; i < 8; i++) begin
      en = 0; step();
      write_cell(3, 2, tbl[i].level);
      global_brightness = 8'(tbl[i].gb); led_period = 24'(tbl[i].period);
      en = 1;
      slot_duty(3, 2, -1, 0, on);
      check_val($sformatf("duty[%0d]", i), on, tbl[i].exp_on);
    end

    // mid-slot write only affects the following frame
    en = 0; step();
    write_cell(3, 2, 200);
    global_brightness = 8'd255; led_period = 24'd256; en = 1;
    slot_duty(3, 2, 10, 10, on);
    check_val("midslot_keep", on, 200);
    slot_duty(3, 2, -1, 0, on);
    check_val("midslot_next", on, 10);

    // out-of-range writes are discarded
    do_reset();
    write_cell(12, 2, 255); write_cell(3, 9, 255); write_cell(15, 15, 255);
    led_period = 24'd1; global_brightness = 8'd255; en = 1;
    scan_any_lit(2*N*(B+1) + 2, lit);
    check_val("oor_dark", lit, 0);

    // clear with simultaneous write, then restarted sweep
    en = 0; step();
    for (int n = 0; n < N; n++) write_cell(n, n % M, 50 + n);
    clear = 1; wr = 1; wr_n = 4'd4; wr_m = 4'd4; wr_level = 8'd77;
    step();
    clear = 0; wr = 0; c = 0;
    while (!wr_ready && c < 50) begin c++; if (c == 3) wr = 1; step(); wr = 0; end
    check_val("clr_rdy_low", c, N);
    write_cell(1, 1, 99);
    clear = 1; step(); clear = 0;
    repeat (3) step();
    clear = 1; step(); clear = 0; c = 0;
    while (!wr_ready && c < 50) begin c++; step(); end
    check_val("reclr_rdy_low", c, N);
    en = 1; led_period = 24'd1;
    scan_any_lit(N*(B+1) + 2, lit);
    check_val("clr_dark", lit, 0);

    // en drop mid-DRIVE of group 5, then restart at group 0
    en = 0; step();
    for (int m = 0; m < M; m++) write_cell(5, m, 255);
    led_period = 24'd20; en = 1;
    c = 0;
    while (!n_en[5] && c < 2000) begin step(); c++; end
    repeat (3) step();
    check_val("g5_lit", int'(m_en != 0), 1);
    en = 0; step();
    check_val("en_drop", int'({n_en, m_en, done_tick, busy}), 0);
    en = 1; c = 0;
    do begin step(); c++; end while (n_en == 0 && c < 100);
    check_val("restart_lat", c, B + 1);
    check_val("restart_grp", int'(n_en), 1);

    // reset mid-sweep returns to reset values immediately
    clear = 1; step(); clear = 0;
    repeat (2) step();
    @(negedge clk);
    reset = 1; #1;
    check_val("rst_mid_out", int'({n_en, m_en, done_tick, busy}), 0);
    check_val("rst_mid_rdy", int'(wr_ready), 1);
    model_reset();
    en = 0;
    @(posedge clk); #1;
    reset = 0;

    // randomized traffic against the model
    led_period = 24'd3; en = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) global_brightness = 8'($urandom);
      wr = ($urandom_range(0, 2) == 0);
      wr_n = 4'($urandom_range(0, 11)); wr_m = 4'($urandom_range(0, 9));
      wr_level = 8'($urandom);
      clear = ($urandom_range(0, 199) == 0);
      if (!en) led_period = 24'($urandom_range(0, 12));
      if ($urandom_range(0, 399) == 0) en = ~en;
      step();
    end
    wr = 0; clear = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
